// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - circular instruction-register queue on a shared system bus
// Optional sticky overflow flag enabled by defining IR_QUEUE_OVF_EN.
module ir_queue #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         load_IR,
  input  logic                         next_IR,
  input  logic                         flush,
  input  logic                         Addr_bus,
  inout  wire  [WORD_W-1:0]            sysbus,
  output logic [OP_W-1:0]              op,
  output logic                         valid,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef IR_QUEUE_OVF_EN
  ,
  output logic                         ovf
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] head_word;
  logic              push, pop;

  assign valid     = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_word = mem_q[head_q];

  // A pop frees a slot this cycle, so a full queue may still accept a push.
  always_comb begin
    pop     = next_IR & valid & ~flush;
    push    = load_IR & ~Addr_bus & ~flush & (~full | pop);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately unreset; count gates every read of it.
  always_ff @(posedge clock) begin
    if (push) mem_q[tail_q] <= sysbus;
  end

  assign op     = valid ? head_word[WORD_W-1 -: OP_W] : '0;
  assign sysbus = (Addr_bus && valid) ? {{OP_W{1'b0}}, head_word[WORD_W-OP_W-1:0]}
                                      : {WORD_W{1'bz}};

`ifdef IR_QUEUE_OVF_EN
  logic ovf_q, ovf_d;
  logic drop;

  always_comb begin
    drop  = load_IR & ~Addr_bus & ~flush & full & ~pop;
    ovf_d = flush ? 1'b0 : (ovf_q | drop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - directed self-checking bench for ir_queue
module tb_ir_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_IR = 1'b0;
  logic       next_IR = 1'b0;
  logic       flush = 1'b0;
  logic       Addr_bus = 1'b0;
  logic       tb_drive = 1'b1;
  logic [7:0] tb_data = 8'h00;
  wire  [7:0] sysbus;
  logic [2:0] op;
  logic       valid;
  logic       full;
  logic [2:0] count;
`ifdef IR_QUEUE_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  assign sysbus = tb_drive ? tb_data : 8'hzz;

  always #5 clock = ~clock;

  ir_queue #(.WORD_W(8), .OP_W(3), .DEPTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .load_IR  (load_IR),
    .next_IR  (next_IR),
    .flush    (flush),
    .Addr_bus (Addr_bus),
    .sysbus   (sysbus),
    .op       (op),
    .valid    (valid),
    .full     (full),
    .count    (count)
`ifdef IR_QUEUE_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    tb_data = w;
    load_IR = 1'b1;
    step();
    load_IR = 1'b0;
  endtask

  task automatic read_head(input string tag, input logic [7:0] exp);
    Addr_bus = 1'b1;
    tb_drive = 1'b0;
    #1;
    check({tag, "_op"}, 32'(op), 32'(exp[7:5]));
    check({tag, "_bus"}, 32'(sysbus), {27'd0, exp[4:0]});
    Addr_bus = 1'b0;
    tb_drive = 1'b1;
  endtask

  logic [7:0] wrap_in   [8] = '{8'h0F, 8'h2E, 8'h4D, 8'h6C, 8'h8B, 8'hAA, 8'hC9, 8'hE8};
  logic [7:0] wrap_head [8] = '{8'h33, 8'h44, 8'h77, 8'h0F, 8'h2E, 8'h4D, 8'h6C, 8'h8B};
  logic [7:0] drain     [4] = '{8'h8B, 8'hAA, 8'hC9, 8'hE8};

  initial begin
    step();
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_full", 32'(full), 0);
    check("rst_op", 32'(op), 0);
    reset = 1'b0;
    step();

    push_word(8'hA5);
    check("lat1_op", 32'(op), 32'h5);
    check("lat1_valid", 32'(valid), 1);
    push_word(8'h3C);
    check("two_count", 32'(count), 2);
    check("two_op", 32'(op), 32'h5);
    next_IR = 1'b1; step(); next_IR = 1'b0;
    check("pop_op", 32'(op), 32'h1);
    check("pop_count", 32'(count), 1);
    next_IR = 1'b1; step(); next_IR = 1'b0;
    check("empty_valid", 32'(valid), 0);
    check("empty_op", 32'(op), 0);

    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    push_word(8'h55);
    check("ovf5_count", 32'(count), 4);
    check("ovf5_full", 32'(full), 1);
`ifdef IR_QUEUE_OVF_EN
    check("ovf5_flag", 32'(ovf), 1);
`endif
    read_head("full_head", 8'h11);

    tb_data = 8'h77; load_IR = 1'b1; next_IR = 1'b1;
    step();
    load_IR = 1'b0; next_IR = 1'b0;
    check("fullpp_count", 32'(count), 4);
    read_head("fullpp_head", 8'h22);

    for (int i = 0; i < 8; i++) begin
      tb_data = wrap_in[i]; load_IR = 1'b1; next_IR = 1'b1;
      step();
      load_IR = 1'b0; next_IR = 1'b0;
      check($sformatf("wrap_count%0d", i), 32'(count), 4);
      read_head($sformatf("wrap_head%0d", i), wrap_head[i]);
    end
    for (int i = 0; i < 4; i++) begin
      read_head($sformatf("drain%0d", i), drain[i]);
      next_IR = 1'b1; step(); next_IR = 1'b0;
    end
    check("drained_valid", 32'(valid), 0);

    tb_data = 8'hE2; load_IR = 1'b1; next_IR = 1'b1;
    step();
    load_IR = 1'b0; next_IR = 1'b0;
    check("emptypp_count", 32'(count), 1);
    check("emptypp_op", 32'(op), 32'h7);

    flush = 1'b1; step(); flush = 1'b0;
    check("flush_count", 32'(count), 0);
`ifdef IR_QUEUE_OVF_EN
    check("flush_ovf", 32'(ovf), 0);
`endif

    push_word(8'hB9);
    read_head("addr_b9", 8'hB9);
    Addr_bus = 1'b1; tb_drive = 1'b0; load_IR = 1'b1;
    step();
    Addr_bus = 1'b0; tb_drive = 1'b1; load_IR = 1'b0;
    check("addr_nopush", 32'(count), 1);
    next_IR = 1'b1; step(); next_IR = 1'b0;
    tb_data = 8'hC3; Addr_bus = 1'b1;
    #1;
    check("empty_bus_z", 32'(sysbus), 32'hC3);
    check("empty_addr_op", 32'(op), 0);
    Addr_bus = 1'b0;

    push_word(8'h01);
    push_word(8'h02);
    push_word(8'h03);
    check("three_count", 32'(count), 3);
    tb_data = 8'h04; load_IR = 1'b1; flush = 1'b1;
    step();
    load_IR = 1'b0; flush = 1'b0;
    check("pushflush_count", 32'(count), 0);
    check("pushflush_valid", 32'(valid), 0);

    push_word(8'h05);
    push_word(8'h06);
    check("prerst_count", 32'(count), 2);
    tb_data = 8'h07; load_IR = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("async_count", 32'(count), 0);
    check("async_valid", 32'(valid), 0);
    step();
    check("inrst_count", 32'(count), 0);
    reset = 1'b0; load_IR = 1'b0;
    step();
    check("postrst_count", 32'(count), 0);

    push_word(8'h5A);
    check("final_count", 32'(count), 1);
    check("final_op", 32'(op), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
